dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Multi-cycle data-memory access sequencer between the decoder's MemRead/MemWrite codes and a
//  variable-latency req/gnt/rvalid memory bus. Accepts one load/store per instruction, stalls the
//  core (PC/regfile hold) until the access finishes, generates byte lanes, sign/zero-extends loads,
//  and flags misaligned or timed-out accesses.
// PARAMETERS
//  TIMEOUT  15  max cycles spent in REQ+WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1   clock, rising edge
//  rstn         in   1   async active-low reset
//  mem_read     in   3   001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU, other = none
//  mem_write    in   2   01 SW, 10 SH, 11 SB, 00 = none
//  addr         in   32  byte address (ALU result)
//  wdata        in   32  store data (rs2), low bits used for SH/SB
//  stall        out  1   hold core this cycle
//  load_data    out  32  extended load result, valid in DONE
//  misalign_err out  1   1-cycle pulse: misaligned access, no bus activity
//  timeout_err  out  1   1-cycle pulse: bus did not finish within TIMEOUT
//  bus_req      out  1   request, held until bus_gnt
//  bus_we       out  1   1 store, 0 load
//  bus_addr     out  32  {addr[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_gnt      in   1   request accepted (write completes here)
//  bus_rvalid   in   1   read data valid
//  bus_rdata    in   32  read word
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DONE, ERR. Reset: state IDLE, all outputs 0, counter 0.
//  op_valid = legal mem_read code | mem_write!=0. Both set: store wins, load ignored.
//  stall = (IDLE & op_valid) | REQ | WAIT. DONE and ERR drive stall=0 (instruction retires).
//  IDLE & op_valid: latch op/addr/wdata. Misaligned (W: addr[1:0]!=0; H/HU: addr[0]) -> ERR;
//   else -> REQ. Latched values keep bus_* stable regardless of input changes.
//  REQ: bus_req=1. gnt & store -> DONE; gnt & load -> WAIT. bus_req drops the cycle after gnt.
//  WAIT: bus_rvalid -> capture/extend into load_data, -> DONE. rvalid outside WAIT ignored.
//  DONE: 1 cycle, -> IDLE. IDLE samples next instruction the following cycle (no re-issue).
//  ERR: 1 cycle, pulse the error output, load_data=0, -> IDLE.
//  Timeout: counter clears on IDLE exit, increments each REQ/WAIT cycle; at TIMEOUT, drop
//   bus_req, -> ERR with timeout_err (gnt/rvalid on that cycle lost).
//  Lanes: SW be=1111; SH be=0011/1100 by addr[1], wdata={2{wdata[15:0]}};
//   SB be=0001<<addr[1:0], wdata={4{wdata[7:0]}}. Loads: bus_be = same pattern as store width.
//  Load extract: byte/half selected by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  load_data holds until next load completes or error.
//  Latency (gnt same cycle as REQ, rvalid next): load 3 stall cycles, store 2.
//  rstn low mid-access: immediate return to IDLE, bus_req=0, no error pulse.
// TESTING
//  LW addr 0x100, gnt at 1st REQ, rvalid+1 rdata 0xDEADBEEF -> stall 3 cycles, load_data 0xDEADBEEF.
//  LB addr 0x103, rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
//  SB addr 0x22, wdata 0x000000A5 -> be 0100, bus_wdata 0xA5A5A5A5, bus_we=1, stall 2 cycles.
//  LH addr 0x101 -> misalign_err pulse, bus_req never asserted, stall 1 cycle.
//  TIMEOUT=15, gnt never asserted -> bus_req 15 cycles, timeout_err pulse, back to IDLE.
//  rstn low while WAIT -> bus_req/stall 0 at once; next LW completes normally.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: multi-cycle load/store sequencer onto a req/gnt/rvalid bus,
// with byte-lane generation, load extension, misalign and timeout detection.
module dmem_bus_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_size, r_off;
    logic          r_uns, r_mis, r_we;
    logic [31:0]   r_addr, r_wdata, r_load;
    logic [3:0]    r_be;
    logic          w_st, w_ld, w_valid, w_uns, w_mis, w_to;
    logic [1:0]    w_size;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ext;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // size encoding: 0 word, 1 half, 2 byte; a store overrides any load code
    assign w_st    = mem_write != 2'b00;
    assign w_ld    = mem_read >= 3'd1 && mem_read <= 3'd5;
    assign w_valid = w_st | w_ld;
    assign w_size  = w_st ? mem_write - 2'd1 : (mem_read == 3'd1 ? 2'd0 : mem_read <= 3'd3 ? 2'd1 : 2'd2);
    assign w_uns   = !w_st && (mem_read == 3'd3 || mem_read == 3'd5);
    assign w_mis   = (w_size == 2'd0 && addr[1:0] != 2'b00) || (w_size == 2'd1 && addr[0]);
    assign w_be    = w_size == 2'd0 ? 4'b1111 : w_size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    assign w_wdata = w_size == 2'd0 ? wdata : w_size == 2'd1 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign w_to    = r_cnt == CW'(TIMEOUT);
    assign w_byte  = bus_rdata[{r_off, 3'b000} +: 8];
    assign w_half  = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign w_ext   = r_size == 2'd0 ? bus_rdata :
                     r_size == 2'd1 ? {{16{~r_uns & w_half[15]}}, w_half} : {{24{~r_uns & w_byte[7]}}, w_byte};

    assign load_data = r_load;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        stall        = 1'b0;
        bus_req      = 1'b0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        case (r_state)
            IDLE: begin
                stall  = rstn & w_valid;
                w_next = w_valid ? (w_mis ? ERR : REQ) : IDLE;
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = !w_to;
                w_next  = w_to ? ERR : bus_gnt ? (r_we ? DONE : WAIT) : REQ;
            end
            WAIT: begin
                stall  = 1'b1;
                w_next = w_to ? ERR : bus_rvalid ? DONE : WAIT;
            end
            DONE: w_next = IDLE;
            ERR: begin
                misalign_err = r_mis;
                timeout_err  = !r_mis;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_size  <= 2'd0;
            r_off   <= 2'd0;
            r_uns   <= 1'b0;
            r_mis   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_load  <= '0;
        end else begin
            r_cnt <= (r_state == REQ || r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && w_valid) begin
                r_size  <= w_size;
                r_off   <= addr[1:0];
                r_uns   <= w_uns;
                r_mis   <= w_mis;
                r_we    <= w_st;
                r_addr  <= {addr[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_st ? w_wdata : '0;
            end
            if (w_next == ERR)                         r_load <= '0;
            else if (r_state == WAIT && bus_rvalid)    r_load <= w_ext;
        end
    end
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: scoreboard bench for dmem_bus_ctrl; a bus responder
// drives gnt/rvalid with programmable latency and records what the DUT did.
module tb_dmem_bus_ctrl;
    logic        clk = 1'b0, rstn = 1'b0;
    logic [2:0]  mem_read = '0;
    logic [1:0]  mem_write = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, misalign_err, timeout_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    dmem_bus_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .misalign_err(misalign_err), .timeout_err(timeout_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic [31:0] ad;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n = 0, nf = 0;
    logic [31:0] last_load = '0;
    int          o_stalls, o_reqs;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_ad, o_data;
    logic        o_we, o_mis, o_to, o_done;

    // Model the expectation, then play bus slave until the instruction retires.
    task automatic run_access(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd,
                              input int gl, input int rl, input logic [31:0] rd);
        exp_t x;
        int sz, since;
        logic uns, mis, seen;
        logic [31:0] sh;
        case (mw)
            2'd1: sz = 4;
            2'd2: sz = 2;
            2'd3: sz = 1;
            default: case (mr)
                3'd1:       sz = 4;
                3'd2, 3'd3: sz = 2;
                default:    sz = 1;
            endcase
        endcase
        uns = (mw == 2'd0) && (mr == 3'd3 || mr == 3'd5);
        mis = (a & 32'(sz - 1)) != 0;
        sh = rd >> {a[1:0], 3'b000};
        x.we = mw != 2'd0;
        x.ad = a & ~32'h3;
        x.be = sz == 4 ? 4'hF : sz == 2 ? 4'h3 << a[1:0] : 4'h1 << a[1:0];
        x.wd = !x.we ? 32'h0 : sz == 4 ? wd : sz == 2 ? {wd[15:0], wd[15:0]} : {4{wd[7:0]}};
        x.kind = mis ? 1 : gl >= 15 ? 2 : 0;
        if (x.kind != 0) x.data = 32'h0;
        else if (x.we) x.data = last_load;
        else if (sz == 4) x.data = rd;
        else if (sz == 2) x.data = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else x.data = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        last_load = x.data;
        x.stalls = x.kind == 1 ? 1 : x.kind == 2 ? 17 : x.we ? gl + 2 : gl + 2 + rl;
        x.reqs = x.kind == 1 ? 0 : x.kind == 2 ? 15 : gl + 1;
        sb.push_back(x);
        mem_read = mr; mem_write = mw; addr = a; wdata = wd;
        o_stalls = 0; o_reqs = 0; o_done = 0; o_mis = 0; o_to = 0;
        o_be = 'x; o_wd = 'x; o_ad = 'x; o_we = 1'bx; o_data = 'x;
        since = -1; seen = 0;
        for (int c = 0; c < 80 && !o_done; c++) begin
            #1;
            if (stall) begin seen = 1; o_stalls++; end
            else if (seen) begin o_done = 1; o_data = load_data; end
            if (seen) begin o_mis |= misalign_err; o_to |= timeout_err; end
            bus_gnt = 0; bus_rvalid = 0;
            if (bus_req) begin
                if (o_reqs == 0) begin o_be = bus_be; o_wd = bus_wdata; o_ad = bus_addr; o_we = bus_we; end
                if (o_reqs == gl) begin bus_gnt = 1; since = 0; end
                o_reqs++;
            end else if (since >= 0) begin
                since++;
                if (since == rl) begin bus_rvalid = 1; bus_rdata = rd; end
            end
            if (!o_done) @(negedge clk);
        end
        bus_gnt = 0; bus_rvalid = 0;
        e = sb.pop_front();
    endtask

    task automatic idle;
        mem_read = '0; mem_write = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n++; if (stall !== 1'b0) begin nf++; $display("FAIL reset_stall got %b want 0", stall); end
        n++; if (bus_req !== 1'b0) begin nf++; $display("FAIL reset_req got %b want 0", bus_req); end
        n++; if ({bus_be, bus_addr, bus_wdata, bus_we} !== '0) begin nf++; $display("FAIL reset_bus got %h %h %h %b want 0", bus_be, bus_addr, bus_wdata, bus_we); end
        n++; if ({load_data, misalign_err, timeout_err} !== '0) begin nf++; $display("FAIL reset_out got %h %b %b want 0", load_data, misalign_err, timeout_err); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw;
        run_access(3'd1, 2'd0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        n++; if (o_done !== 1'b1) begin nf++; $display("FAIL lw_done got %b want 1", o_done); end
        n++; if (o_data !== e.data) begin nf++; $display("FAIL lw_data got %h want %h", o_data, e.data); end
        n++; if (o_stalls != e.stalls) begin nf++; $display("FAIL lw_stall got %0d want %0d", o_stalls, e.stalls); end
        n++; if ({o_be, o_ad, o_we} !== {e.be, e.ad, e.we}) begin nf++; $display("FAIL lw_bus got %h %h %b want %h %h %b", o_be, o_ad, o_we, e.be, e.ad, e.we); end
        idle();
    endtask

    task automatic test_back_to_back;
        run_access(3'd4, 2'd0, 32'h103, 32'h0, 0, 1, 32'h80112233);
        n++; if ({o_be, o_data} !== {e.be, e.data}) begin nf++; $display("FAIL lb got be %b data %h want %b %h", o_be, o_data, e.be, e.data); end
        run_access(3'd5, 2'd0, 32'h103, 32'h0, 0, 1, 32'h80112233);
        n++; if ({o_be, o_data, o_stalls} !== {e.be, e.data, e.stalls}) begin nf++; $display("FAIL lbu got %b %h %0d want %b %h %0d", o_be, o_data, o_stalls, e.be, e.data, e.stalls); end
        run_access(3'd4, 2'd0, 32'h101, 32'h0, 1, 2, 32'h0000_7F00);
        n++; if ({o_be, o_data, o_stalls} !== {e.be, e.data, e.stalls}) begin nf++; $display("FAIL lb_pos got %b %h %0d want %b %h %0d", o_be, o_data, o_stalls, e.be, e.data, e.stalls); end
        idle();
    endtask

    task automatic test_half;
        run_access(3'd2, 2'd0, 32'h102, 32'h0, 0, 1, 32'h8001_1234);
        n++; if ({o_be, o_data} !== {e.be, e.data}) begin nf++; $display("FAIL lh got %b %h want %b %h", o_be, o_data, e.be, e.data); end
        run_access(3'd3, 2'd0, 32'h102, 32'h0, 0, 1, 32'h8001_1234);
        n++; if ({o_be, o_data} !== {e.be, e.data}) begin nf++; $display("FAIL lhu got %b %h want %b %h", o_be, o_data, e.be, e.data); end
        run_access(3'd2, 2'd0, 32'h200, 32'h0, 2, 3, 32'h1234_F00D);
        n++; if ({o_be, o_data, o_stalls, o_reqs} !== {e.be, e.data, e.stalls, e.reqs}) begin nf++; $display("FAIL lh_slow got %b %h %0d %0d want %b %h %0d %0d", o_be, o_data, o_stalls, o_reqs, e.be, e.data, e.stalls, e.reqs); end
        idle();
    endtask

    task automatic test_store;
        run_access(3'd0, 2'd3, 32'h22, 32'h0000_00A5, 0, 1, 32'hFFFF_FFFF);
        n++; if ({o_be, o_wd, o_we} !== {e.be, e.wd, e.we}) begin nf++; $display("FAIL sb_bus got %b %h %b want %b %h %b", o_be, o_wd, o_we, e.be, e.wd, e.we); end
        n++; if (o_stalls != e.stalls) begin nf++; $display("FAIL sb_stall got %0d want %0d", o_stalls, e.stalls); end
        n++; if (o_data !== e.data) begin nf++; $display("FAIL sb_hold got %h want %h", o_data, e.data); end
        run_access(3'd0, 2'd2, 32'h06, 32'h1234_BEEF, 0, 9, 32'h0);
        n++; if ({o_be, o_wd, o_ad} !== {e.be, e.wd, e.ad}) begin nf++; $display("FAIL sh got %b %h %h want %b %h %h", o_be, o_wd, o_ad, e.be, e.wd, e.ad); end
        run_access(3'd0, 2'd1, 32'h08, 32'hCAFE_F00D, 3, 9, 32'h0);
        n++; if ({o_be, o_wd, o_stalls, o_reqs} !== {e.be, e.wd, e.stalls, e.reqs}) begin nf++; $display("FAIL sw got %b %h %0d %0d want %b %h %0d %0d", o_be, o_wd, o_stalls, o_reqs, e.be, e.wd, e.stalls, e.reqs); end
        run_access(3'd1, 2'd3, 32'h03, 32'h0000_005A, 0, 9, 32'h0);
        n++; if ({o_be, o_wd, o_we, o_mis} !== {e.be, e.wd, e.we, 1'b0}) begin nf++; $display("FAIL store_wins got %b %h %b %b want %b %h %b 0", o_be, o_wd, o_we, o_mis, e.be, e.wd, e.we); end
        idle();
    endtask

    task automatic test_misalign;
        run_access(3'd2, 2'd0, 32'h101, 32'h0, 0, 1, 32'h0);
        n++; if ({o_mis, o_to} !== {e.kind == 1, e.kind == 2}) begin nf++; $display("FAIL mis_flag got %b%b want %b%b", o_mis, o_to, e.kind == 1, e.kind == 2); end
        n++; if (o_reqs != e.reqs || o_stalls != e.stalls) begin nf++; $display("FAIL mis_bus got req %0d stall %0d want %0d %0d", o_reqs, o_stalls, e.reqs, e.stalls); end
        n++; if (o_data !== e.data) begin nf++; $display("FAIL mis_data got %h want %h", o_data, e.data); end
        run_access(3'd0, 2'd1, 32'h0E, 32'h1, 0, 1, 32'h0);
        n++; if ({o_mis, o_reqs, o_stalls} !== {e.kind == 1, e.reqs, e.stalls}) begin nf++; $display("FAIL mis_sw got %b %0d %0d want %b %0d %0d", o_mis, o_reqs, o_stalls, e.kind == 1, e.reqs, e.stalls); end
        idle();
        n++; if ({misalign_err, stall} !== 2'b00) begin nf++; $display("FAIL mis_pulse got %b%b want 00", misalign_err, stall); end
    endtask

    task automatic test_timeout;
        run_access(3'd1, 2'd0, 32'h300, 32'h0, 99, 1, 32'h0);
        n++; if ({o_to, o_mis} !== {e.kind == 2, e.kind == 1}) begin nf++; $display("FAIL to_flag got %b%b want %b%b", o_to, o_mis, e.kind == 2, e.kind == 1); end
        n++; if (o_reqs != e.reqs) begin nf++; $display("FAIL to_reqs got %0d want %0d", o_reqs, e.reqs); end
        n++; if (o_stalls != e.stalls || o_data !== e.data) begin nf++; $display("FAIL to_end got %0d %h want %0d %h", o_stalls, o_data, e.stalls, e.data); end
        idle();
        n++; if ({timeout_err, bus_req, stall} !== 3'b000) begin nf++; $display("FAIL to_idle got %b%b%b want 000", timeout_err, bus_req, stall); end
    endtask

    task automatic test_reset_mid;
        mem_read = 3'd1; addr = 32'h40;
        @(negedge clk);
        #1 bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        n++; if ({stall, bus_req} !== 2'b10) begin nf++; $display("FAIL wait_state got %b%b want 10", stall, bus_req); end
        rstn = 1'b0;
        #1;
        n++; if ({stall, bus_req} !== 2'b00) begin nf++; $display("FAIL rst_mid got %b%b want 00", stall, bus_req); end
        mem_read = '0;
        @(negedge clk);
        rstn = 1'b1;
        last_load = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n++; if ({misalign_err, timeout_err, stall} !== 3'b000) begin nf++; $display("FAIL rst_noerr got %b%b%b want 000", misalign_err, timeout_err, stall); end
        end
        run_access(3'd1, 2'd0, 32'h40, 32'h0, 0, 1, 32'h1234_5678);
        n++; if ({o_data, o_stalls} !== {e.data, e.stalls}) begin nf++; $display("FAIL rst_next got %h %0d want %h %0d", o_data, o_stalls, e.data, e.stalls); end
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lw();
        test_back_to_back();
        test_half();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n, nf);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
